// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and helpers for the clock divider bank.
//   CH_MAX     largest supported channel count
//   WIDTH_DEF  default half-period width
//   half_t     half-period value at the default width
//   addr_w()   channel-select width for a given channel count (at least 1)
package clkdiv_pkg;

    localparam int CH_MAX    = 16;
    localparam int WIDTH_DEF = 32;

    typedef logic [WIDTH_DEF-1:0] half_t;

    function automatic int addr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// clkdiv_chan: one divider channel.
//   iclk, irst_n  clock, synchronous active-low reset
//   en_i          run enable
//   sync_i        restart in phase (counter and output cleared)
//   we_i, data_i  write of a new half-period into the shadow register
//   oclk_o        divided clock, period 2*H, 50% duty
//   otick_o       one-cycle strobe on each rising transition of oclk_o
// A new half-period sits in the shadow register and is copied into the active
// register only at a wrap, or whenever the channel is idle, so a period never
// gets cut short.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int          WIDTH        = WIDTH_DEF,
    parameter int unsigned DEFAULT_HALF = 2
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             we_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             oclk_o,
    output logic             otick_o
);

    localparam logic [WIDTH-1:0] DEF_H = WIDTH'(DEFAULT_HALF);

    logic [WIDTH-1:0] h_s_q, h_s_d;
    logic [WIDTH-1:0] h_a_q, h_a_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wrap;

    always_comb begin
        // A same-edge write bypasses straight into the active-register load.
        h_s_d  = we_i ? data_i : h_s_q;
        h_a_d  = h_a_q;
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        wrap   = (cnt_q == (h_a_q - WIDTH'(1)));

        if (sync_i || !en_i || (h_a_q == '0)) begin
            cnt_d = '0;
            clk_d = 1'b0;
            h_a_d = h_s_d;
        end else if (wrap) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            tick_d = ~clk_q;
            h_a_d  = h_s_d;
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            h_s_q  <= DEF_H;
            h_a_q  <= DEF_H;
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            h_s_q  <= h_s_d;
            h_a_q  <= h_a_d;
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign oclk_o  = clk_q;
    assign otick_o = tick_q;

endmodule

// File: rtl/clkdiv_bank.sv
// clkdiv_bank: NUM_CH independent programmable clock dividers.
//   iclk, irst_n  system clock, synchronous active-low reset
//   ien           per-channel run enable
//   isync         one-cycle pulse restarting every channel in phase
//   iwe, iaddr    half-period write strobe and channel select
//   idata         new half-period value
//   oclk          divided clocks
//   otick         one-cycle strobes on each oclk rising transition
module clkdiv_bank
    import clkdiv_pkg::*;
#(
    parameter  int          NUM_CH       = 4,
    parameter  int          WIDTH        = 32,
    parameter  int unsigned DEFAULT_HALF = 2,
    localparam int          AW           = addr_w(NUM_CH)
) (
    input  logic              iclk,
    input  logic              irst_n,
    input  logic [NUM_CH-1:0] ien,
    input  logic              isync,
    input  logic              iwe,
    input  logic [AW-1:0]     iaddr,
    input  logic [WIDTH-1:0]  idata,
    output logic [NUM_CH-1:0] oclk,
    output logic [NUM_CH-1:0] otick
);

    logic [NUM_CH-1:0] we_ch;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Addresses at or above NUM_CH match no channel, so such writes drop.
        localparam logic [AW-1:0] SEL = AW'(i);

        assign we_ch[i] = iwe && (iaddr == SEL);

        clkdiv_chan #(
            .WIDTH        (WIDTH),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_chan (
            .iclk    (iclk),
            .irst_n  (irst_n),
            .en_i    (ien[i]),
            .sync_i  (isync),
            .we_i    (we_ch[i]),
            .data_i  (idata),
            .oclk_o  (oclk[i]),
            .otick_o (otick[i])
        );
    end

endmodule

// File: tb/tb_clkdiv_bank.sv
module tb_clkdiv_bank;

    localparam int NCH = 3;
    localparam int W   = 8;

    logic           iclk;
    logic           irst_n;
    logic [NCH-1:0] ien;
    logic           isync;
    logic           iwe;
    logic [1:0]     iaddr;
    logic [W-1:0]   idata;
    logic [NCH-1:0] oclk;
    logic [NCH-1:0] otick;

    int n_checks = 0;
    int n_pass   = 0;

    clkdiv_bank #(
        .NUM_CH       (NCH),
        .WIDTH        (W),
        .DEFAULT_HALF (2)
    ) dut (
        .iclk   (iclk),
        .irst_n (irst_n),
        .ien    (ien),
        .isync  (isync),
        .iwe    (iwe),
        .iaddr  (iaddr),
        .idata  (idata),
        .oclk   (oclk),
        .otick  (otick)
    );

    initial begin
        iclk = 1'b0;
        forever #5 iclk = ~iclk;
    end

    typedef struct {
        logic           rst_n;
        logic [NCH-1:0] en;
        logic           sync;
        logic           we;
        logic [1:0]     addr;
        logic [W-1:0]   data;
        logic [NCH-1:0] exp_clk;
        logic [NCH-1:0] exp_tick;
        int             tag;
    } vec_t;

    vec_t vq[$];

    // tag is the edge number used in the hand-derived waveform notes.
    task automatic add(input int tag, input logic rst_n, input logic [NCH-1:0] en,
                       input logic sync, input logic we, input logic [1:0] addr,
                       input logic [W-1:0] data, input logic [NCH-1:0] ck,
                       input logic [NCH-1:0] tk);
        vec_t v;
        v.rst_n = rst_n; v.en = en; v.sync = sync; v.we = we; v.addr = addr;
        v.data = data; v.exp_clk = ck; v.exp_tick = tk; v.tag = tag;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input int tag,
                         input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s edge %0d: got %b expected %b", name, tag, act, exp);
    endtask

    task automatic drive(input vec_t v);
        @(negedge iclk);
        irst_n = v.rst_n; ien = v.en; isync = v.sync;
        iwe = v.we; iaddr = v.addr; idata = v.data;
        @(posedge iclk);
        #1;
        check("oclk", v.tag, oclk, v.exp_clk);
        check("otick", v.tag, otick, v.exp_tick);
    endtask

    task automatic run_queue();
        foreach (vq[k]) drive(vq[k]);
        vq.delete();
    endtask

    initial begin
        irst_n = 1'b0; ien = '1; isync = 1'b0; iwe = 1'b0; iaddr = '0; idata = '0;

        // Reset, then all channels at default H=2: rise every 4 edges.
        add(-1, 0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000);
        add( 0, 0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000);
        add( 1, 1, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000);
        add( 2, 1, 3'b111, 0, 0, 0, 0, 3'b111, 3'b111);
        add( 3, 1, 3'b111, 0, 0, 0, 0, 3'b111, 3'b000);
        add( 4, 1, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000);
        add( 5, 1, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000);
        add( 6, 1, 3'b111, 0, 0, 0, 0, 3'b111, 3'b111);
        add( 7, 1, 3'b111, 0, 0, 0, 0, 3'b111, 3'b000);
        add( 8, 1, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000);
        // ch1 <- 5 in the low phase: old phase finishes, then 5 high / 5 low.
        add( 9, 1, 3'b111, 0, 1, 1, 5, 3'b000, 3'b000);
        add(10, 1, 3'b111, 0, 0, 0, 0, 3'b111, 3'b111);
        add(11, 1, 3'b111, 0, 0, 0, 0, 3'b111, 3'b000);
        add(12, 1, 3'b111, 0, 0, 0, 0, 3'b010, 3'b000);
        add(13, 1, 3'b111, 0, 0, 0, 0, 3'b010, 3'b000);
        add(14, 1, 3'b111, 0, 0, 0, 0, 3'b111, 3'b101);
        add(15, 1, 3'b111, 0, 0, 0, 0, 3'b101, 3'b000);
        add(16, 1, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000);
        add(17, 1, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000);
        add(18, 1, 3'b111, 0, 0, 0, 0, 3'b101, 3'b101);
        add(19, 1, 3'b111, 0, 0, 0, 0, 3'b101, 3'b000);
        add(20, 1, 3'b111, 0, 0, 0, 0, 3'b010, 3'b010);
        // ch2 only: H=1 toggles each edge, H=0 halts, H=3 restarts.
        add(21, 1, 3'b100, 0, 1, 2, 1, 3'b000, 3'b000);
        add(22, 1, 3'b100, 0, 0, 0, 0, 3'b100, 3'b100);
        add(23, 1, 3'b100, 0, 0, 0, 0, 3'b000, 3'b000);
        add(24, 1, 3'b100, 0, 0, 0, 0, 3'b100, 3'b100);
        add(25, 1, 3'b100, 0, 0, 0, 0, 3'b000, 3'b000);
        add(26, 1, 3'b100, 0, 1, 2, 0, 3'b100, 3'b100);
        add(27, 1, 3'b100, 0, 0, 0, 0, 3'b000, 3'b000);
        add(28, 1, 3'b100, 0, 0, 0, 0, 3'b000, 3'b000);
        add(29, 1, 3'b100, 0, 0, 0, 0, 3'b000, 3'b000);
        add(30, 1, 3'b100, 0, 1, 2, 3, 3'b000, 3'b000);
        add(31, 1, 3'b100, 0, 0, 0, 0, 3'b000, 3'b000);
        add(32, 1, 3'b100, 0, 0, 0, 0, 3'b000, 3'b000);
        add(33, 1, 3'b100, 0, 0, 0, 0, 3'b100, 3'b100);
        add(34, 1, 3'b100, 0, 0, 0, 0, 3'b100, 3'b000);
        add(35, 1, 3'b100, 0, 0, 0, 0, 3'b100, 3'b000);
        add(36, 1, 3'b100, 0, 0, 0, 0, 3'b000, 3'b000);
        add(37, 1, 3'b100, 0, 0, 0, 0, 3'b000, 3'b000);
        add(38, 1, 3'b100, 0, 0, 0, 0, 3'b000, 3'b000);
        add(39, 1, 3'b100, 0, 0, 0, 0, 3'b100, 3'b100);
        // ch1 (H=5) alone; drop enable while high, then re-enable.
        add(40, 1, 3'b010, 0, 0, 0, 0, 3'b000, 3'b000);
        add(41, 1, 3'b010, 0, 0, 0, 0, 3'b000, 3'b000);
        add(42, 1, 3'b010, 0, 0, 0, 0, 3'b000, 3'b000);
        add(43, 1, 3'b010, 0, 0, 0, 0, 3'b000, 3'b000);
        add(44, 1, 3'b010, 0, 0, 0, 0, 3'b010, 3'b010);
        add(45, 1, 3'b010, 0, 0, 0, 0, 3'b010, 3'b000);
        add(46, 1, 3'b010, 0, 0, 0, 0, 3'b010, 3'b000);
        add(47, 1, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000);
        add(48, 1, 3'b010, 0, 0, 0, 0, 3'b000, 3'b000);
        add(49, 1, 3'b010, 0, 0, 0, 0, 3'b000, 3'b000);
        add(50, 1, 3'b010, 0, 0, 0, 0, 3'b000, 3'b000);
        add(51, 1, 3'b010, 0, 0, 0, 0, 3'b000, 3'b000);
        add(52, 1, 3'b010, 0, 0, 0, 0, 3'b010, 3'b010);
        add(53, 1, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000);
        // ch0 H=3, ch2 H=5, started out of phase, then isync.
        add(54, 1, 3'b000, 0, 1, 0, 3, 3'b000, 3'b000);
        add(55, 1, 3'b000, 0, 1, 2, 5, 3'b000, 3'b000);
        add(56, 1, 3'b001, 0, 0, 0, 0, 3'b000, 3'b000);
        add(57, 1, 3'b101, 0, 0, 0, 0, 3'b000, 3'b000);
        add(58, 1, 3'b101, 0, 0, 0, 0, 3'b001, 3'b001);
        add(59, 1, 3'b101, 1, 0, 0, 0, 3'b000, 3'b000);
        add(60, 1, 3'b101, 0, 0, 0, 0, 3'b000, 3'b000);
        add(61, 1, 3'b101, 0, 0, 0, 0, 3'b000, 3'b000);
        add(62, 1, 3'b101, 0, 0, 0, 0, 3'b001, 3'b001);
        add(63, 1, 3'b101, 0, 0, 0, 0, 3'b001, 3'b000);
        add(64, 1, 3'b101, 0, 0, 0, 0, 3'b101, 3'b100);
        add(65, 1, 3'b101, 0, 0, 0, 0, 3'b100, 3'b000);
        run_queue();

        // After isync at edge 59: ch0 rises at 62+6k, ch2 at 64+10m;
        // both rise together at 74, 104, 134.
        begin
            int coinc = 0;
            int last_coinc = 0;
            for (int e = 66; e <= 134; e++) begin
                logic [NCH-1:0] ec, et;
                ec = '0; et = '0;
                ec[0] = ((e - 62) % 6) < 3;
                ec[2] = ((e - 64) % 10) < 5;
                et[0] = ((e - 62) % 6) == 0;
                et[2] = ((e - 64) % 10) == 0;
                @(negedge iclk);
                @(posedge iclk);
                #1;
                check("sync_oclk", e, oclk, ec);
                check("sync_otick", e, otick, et);
                if (otick[0] && otick[2]) begin
                    coinc++;
                    last_coinc = e;
                end
            end
            check("coincident_rises", 134, 3'(coinc), 3'd3);
            check("last_coincidence_at_134", 134, 3'(last_coinc == 134), 3'b001);
        end

        // Out-of-range write ignored; write to ch0 together with isync
        // takes effect straight after the sync (ch0 H=2, ch2 still 5).
        add(135, 1, 3'b101, 0, 1, 3, 1, 3'b101, 3'b000);
        add(136, 1, 3'b101, 1, 1, 0, 2, 3'b000, 3'b000);
        add(137, 1, 3'b101, 0, 0, 0, 0, 3'b000, 3'b000);
        add(138, 1, 3'b101, 0, 0, 0, 0, 3'b001, 3'b001);
        add(139, 1, 3'b101, 0, 0, 0, 0, 3'b001, 3'b000);
        add(140, 1, 3'b101, 0, 0, 0, 0, 3'b000, 3'b000);
        add(141, 1, 3'b101, 0, 0, 0, 0, 3'b100, 3'b100);
        add(142, 1, 3'b101, 0, 0, 0, 0, 3'b101, 3'b001);
        add(143, 1, 3'b101, 0, 0, 0, 0, 3'b101, 3'b000);
        add(144, 1, 3'b101, 0, 0, 0, 0, 3'b100, 3'b000);
        add(145, 1, 3'b101, 0, 0, 0, 0, 3'b100, 3'b000);
        add(146, 1, 3'b101, 0, 0, 0, 0, 3'b001, 3'b001);
        // Reset mid-operation wins over sync, write and enables; the
        // defaults (H=2) come back for every channel afterwards.
        add(147, 0, 3'b111, 1, 1, 0, 9, 3'b000, 3'b000);
        add(148, 1, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000);
        add(149, 1, 3'b111, 0, 0, 0, 0, 3'b111, 3'b111);
        add(150, 1, 3'b111, 0, 0, 0, 0, 3'b111, 3'b000);
        add(151, 1, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000);
        run_queue();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
